ann_neuron_par: RTL and testbench
=================================

# ann_neuron_par

Parametrised multi-lane successor to the single-MAC neuron: computes one neuron output as bias + Σ in[i]·wt[i] over N signed elements, processing LANES products per clock.
- Accumulation uses a saturating accumulator.
- An optional ReLU is applied to the result.
- A fixed-point shifted copy of the result is produced alongside the raw value.
- The block sits between the layer sequencer, which supplies vectors and `start`, and the next layer's input buffer, which consumes results on `done`.

## Interface
Parameters:
- `N`, 62, number of input/weight elements
- `W`, 8, element and bias width (signed two's complement)
- `LANES`, 2, products accumulated per cycle (1..N)
- `ACC_W`, 21, accumulator/result width
- `FRAC`, 9, fraction bits removed for the shifted output

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin computation (sampled only when idle)
- `bias`  in  W  signed bias
- `in_vec`  in  W*N  inputs, element i at bits [W*i +: W] of a [0:W*N-1] vector (element 0 is MSB-most)
- `wt_vec`  in  W*N  weights, same packing
- `relu_en`  in  1  clamp negative results to 0
- `busy`  out  1  computation in progress
- `done`  out  1  one-cycle pulse: results valid/updated
- `result_raw`  out  ACC_W  signed result
- `result_shifted`  out  ACC_W  `result_raw` >>> FRAC (arithmetic)
- `ovf`  out  1  saturation occurred during the last computation

## Operation
- States: IDLE, MAC.
- **IDLE, `start`=1:** the following are captured into internal registers, so the input ports may change afterwards:
  - `in_vec`, `wt_vec`, `bias`, `relu_en`
  - acc <= sign-extended bias; idx <= 0; ovf_int <= 0; go to MAC.
- **MAC:** each cycle multiplies elements idx..idx+LANES-1 as W×W signed products.
  - Lanes with index ≥ N contribute 0.
  - Lane products are summed at full width (2W+clog2(LANES) bits), then added to acc with saturation to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets ovf_int (sticky).
  - idx += LANES.
- **Last MAC cycle** (idx+LANES ≥ N): the next edge performs these updates and returns to IDLE:
  - writes `result_raw` = final acc, or 0 if relu_en and acc<0
  - writes `result_shifted` = `result_raw` >>> FRAC
  - writes `ovf` = ovf_int, including the clamp from that last add
  - pulses `done`
- ReLU does not clear `ovf`.
- `start` while in MAC is ignored.
- Outputs hold their values between `done` pulses.

## Timing
- C = ceil(N/LANES) MAC cycles.
- Edge 0: `start` sampled in IDLE; `busy` goes high after edge 0.
- Edges 1..C: accumulate.
- Edge C: results registered, `done`=1 and `busy`=0 during the following cycle. Latency from start edge to `done` is C edges (N=62, LANES=2 → 31).
- `done` cleared at the next edge.
- A `start` sampled in the `done` cycle is accepted (back-to-back, no bubble).
- Reset (async, any state) brings the block to this state:
  - state IDLE
  - `busy`=0, `done`=0, `ovf`=0
  - `result_raw`=0, `result_shifted`=0
  - idx=0, acc=0
- Reset asserted mid-computation aborts it with no `done`.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Shared package `ann_pkg`:
  - state enum (IDLE, MAC)
  - default ACC_W/FRAC constants
  - saturating-add function `sat_add(acc, sum)` returning {clamped value, clamp flag}
- Sub-module `ann_mac_lane`: one signed W×W multiplier with an element-valid gate that outputs 0 when the lane index is ≥ N. It is instantiated LANES times via generate.
- Control (state, idx, busy/done) and the accumulator live in the top module; no separate controller module.

## Test plan
- N=4, LANES=2, all inputs 1, weights 2, bias 3, relu_en=0 -> `result_raw`=11, `result_shifted`=0, `ovf`=0, `done` after edge 2, `busy` high edges 1–2.
- N=5, LANES=2, inputs 1..5, weights 1, bias −2 -> padding lane ignored, `result_raw`=13, `done` after edge 3.
- N=62, LANES=2, inputs −128, weights 127, bias 0:
  - relu_en=0 -> `result_raw`=−1007872, `result_shifted`=−1969
  - relu_en=1 -> both outputs 0, `ovf`=0
- N=64, LANES=4, inputs −128, weights −128, bias 0 -> `result_raw`=1048575 (saturated), `ovf`=1.
- Pulse `start` again mid-MAC with changed vectors -> ignored, result from the first capture. Then assert `rst` mid-MAC -> outputs 0, no `done`. A fresh run then completes correctly.
- Hold `start` high continuously for two runs -> second run starts in the `done` cycle of the first. Its `done` follows C edges later.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared types and helpers for the parallel-lane neuron: FSM states, default
// result widths and the saturating accumulate used by the MAC datapath.
package ann_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_e;

   localparam int ACC_W_DEF = 21;
   localparam int FRAC_DEF  = 9;

   typedef logic signed [63:0] wide_t;

   typedef struct packed {
      wide_t val;
      logic  clamp;
   } sat_t;

   // Add at 64-bit width, then clamp into the signed acc_w-bit range.
   function automatic sat_t sat_add(input wide_t acc, input wide_t sum, input int acc_w);
      wide_t s_v;
      wide_t hi_v;
      wide_t lo_v;
      sat_t  r_v;
      s_v  = acc + sum;
      hi_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo_v = -hi_v - 64'sd1;
      if (s_v > hi_v) begin
         r_v.val   = hi_v;
         r_v.clamp = 1'b1;
      end else if (s_v < lo_v) begin
         r_v.val   = lo_v;
         r_v.clamp = 1'b1;
      end else begin
         r_v.val   = s_v;
         r_v.clamp = 1'b0;
      end
      return r_v;
   endfunction

endpackage

// File: rtl/ann_neuron_par_if.sv
// Sequencer-facing bundle of the neuron: vectors and start in, results and
// status out. The master side is the layer sequencer / next-layer buffer.
interface ann_neuron_par_if #(
   parameter int N     = 62,
   parameter int W     = 8,
   parameter int ACC_W = 21
);
   logic                    start;
   logic signed [W-1:0]     bias;
   logic [0:W*N-1]          in_vec;
   logic [0:W*N-1]          wt_vec;
   logic                    relu_en;
   logic                    busy;
   logic                    done;
   logic signed [ACC_W-1:0] result_raw;
   logic signed [ACC_W-1:0] result_shifted;
   logic                    ovf;

   modport master (
      output start, bias, in_vec, wt_vec, relu_en,
      input  busy, done, result_raw, result_shifted, ovf
   );

   modport slave (
      input  start, bias, in_vec, wt_vec, relu_en,
      output busy, done, result_raw, result_shifted, ovf
   );
endinterface

// File: rtl/ann_mac_lane.sv
// One signed W x W multiplier lane; a lane past the end of the vector
// contributes zero so the last partial group needs no special casing.
module ann_mac_lane #(
   parameter int W = 8
) (
   input  logic signed [W-1:0]   a_i,
   input  logic signed [W-1:0]   b_i,
   input  logic                  valid_i,
   output logic signed [2*W-1:0] prod_o
);

   always_comb begin
      if (valid_i) begin
         prod_o = a_i * b_i;
      end else begin
         prod_o = {(2*W){1'b0}};
      end
   end

endmodule

// File: rtl/ann_neuron_par.sv
// Multi-lane neuron: bias + sum(in[i]*wt[i]) with LANES products per clock,
// saturating accumulation, optional ReLU and a fixed-point shifted copy.
module ann_neuron_par
   import ann_pkg::*;
#(
   parameter int N     = 62,
   parameter int W     = 8,
   parameter int LANES = 2,
   parameter int ACC_W = ACC_W_DEF,
   parameter int FRAC  = FRAC_DEF
) (
   input logic              clk,
   input logic              rst,
   ann_neuron_par_if.slave  bus
);

   localparam int SUM_W = 2*W + $clog2(LANES);
   localparam int IDX_W = $clog2(N + LANES) + 1;

   state_e                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [0:W*N-1]          in_q;
   logic [0:W*N-1]          wt_q;
   logic                    relu_q;
   logic                    ovf_int_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    ovf_q;
   logic signed [ACC_W-1:0] result_raw_q;
   logic signed [ACC_W-1:0] result_shifted_q;

   logic signed [2*W-1:0]   prod_s [LANES];
   logic signed [SUM_W-1:0] sum_s;
   sat_t                    sat_s;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] raw_d;
   logic                    last_s;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [IDX_W-1:0] eidx_s;
      logic             valid_s;

      // Element index for this lane; out-of-range lanes read element 0 and are gated off.
      always_comb begin
         if (int'(idx_q) + l < N) begin
            valid_s = 1'b1;
            eidx_s  = idx_q + IDX_W'(l);
         end else begin
            valid_s = 1'b0;
            eidx_s  = {IDX_W{1'b0}};
         end
      end

      ann_mac_lane #(.W(W)) u_lane (
         .a_i     (in_q[W*eidx_s +: W]),
         .b_i     (wt_q[W*eidx_s +: W]),
         .valid_i (valid_s),
         .prod_o  (prod_s[l])
      );
   end

   // Full-width lane sum, saturating add and the ReLU'd final value.
   always_comb begin
      sum_s = {SUM_W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         sum_s = sum_s + SUM_W'(prod_s[l]);
      end
      sat_s  = sat_add(wide_t'(acc_q), wide_t'(sum_s), ACC_W);
      acc_d  = sat_s.val[ACC_W-1:0];
      last_s = (int'(idx_q) + LANES >= N);
      if (relu_q && acc_d[ACC_W-1]) begin
         raw_d = {ACC_W{1'b0}};
      end else begin
         raw_d = acc_d;
      end
   end

   // Control FSM, accumulator and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         idx_q            <= {IDX_W{1'b0}};
         acc_q            <= {ACC_W{1'b0}};
         in_q             <= {(W*N){1'b0}};
         wt_q             <= {(W*N){1'b0}};
         relu_q           <= 1'b0;
         ovf_int_q        <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         ovf_q            <= 1'b0;
         result_raw_q     <= {ACC_W{1'b0}};
         result_shifted_q <= {ACC_W{1'b0}};
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  in_q      <= bus.in_vec;
                  wt_q      <= bus.wt_vec;
                  relu_q    <= bus.relu_en;
                  acc_q     <= ACC_W'(bus.bias);
                  idx_q     <= {IDX_W{1'b0}};
                  ovf_int_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= MAC;
               end
            end
            MAC: begin
               acc_q     <= acc_d;
               ovf_int_q <= ovf_int_q | sat_s.clamp;
               idx_q     <= idx_q + IDX_W'(LANES);
               if (last_s) begin
                  state_q          <= IDLE;
                  busy_q           <= 1'b0;
                  done_q           <= 1'b1;
                  result_raw_q     <= raw_d;
                  result_shifted_q <= raw_d >>> FRAC;
                  ovf_q            <= ovf_int_q | sat_s.clamp;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.ovf            = ovf_q;
   assign bus.result_raw     = result_raw_q;
   assign bus.result_shifted = result_shifted_q;

endmodule

// File: tb/tb_ann_neuron_par.sv
// Directed bench for ann_neuron_par across four N/LANES configurations,
// with hand-computed results, latencies and control-path scenarios.
module tb_ann_neuron_par;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   ann_neuron_par_if #(.N(4),  .W(8), .ACC_W(21)) if_a ();
   ann_neuron_par_if #(.N(5),  .W(8), .ACC_W(21)) if_b ();
   ann_neuron_par_if #(.N(62), .W(8), .ACC_W(21)) if_c ();
   ann_neuron_par_if #(.N(64), .W(8), .ACC_W(21)) if_d ();

   ann_neuron_par #(.N(4),  .W(8), .LANES(2), .ACC_W(21), .FRAC(9)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   ann_neuron_par #(.N(5),  .W(8), .LANES(2), .ACC_W(21), .FRAC(9)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   ann_neuron_par #(.N(62), .W(8), .LANES(2), .ACC_W(21), .FRAC(9)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
   ann_neuron_par #(.N(64), .W(8), .LANES(4), .ACC_W(21), .FRAC(9)) u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      if_a.start = 1'b0; if_a.bias = '0; if_a.in_vec = '0; if_a.wt_vec = '0; if_a.relu_en = 1'b0;
      if_b.start = 1'b0; if_b.bias = '0; if_b.in_vec = '0; if_b.wt_vec = '0; if_b.relu_en = 1'b0;
      if_c.start = 1'b0; if_c.bias = '0; if_c.in_vec = '0; if_c.wt_vec = '0; if_c.relu_en = 1'b0;
      if_d.start = 1'b0; if_d.bias = '0; if_d.in_vec = '0; if_d.wt_vec = '0; if_d.relu_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if_a.busy); end
      checks++; if (if_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", if_a.done); end
      checks++; if (if_a.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", if_a.ovf); end
      checks++; if (if_c.result_raw !== 21'sd0) begin errors++; $display("FAIL reset_raw got=%0d exp=0", if_c.result_raw); end
      checks++; if (if_d.result_shifted !== 21'sd0) begin errors++; $display("FAIL reset_shifted got=%0d exp=0", if_d.result_shifted); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n;
      bit busy_bad;
      for (int i = 0; i < 4; i++) begin
         if_a.in_vec[8*i +: 8] = 8'sd1;
         if_a.wt_vec[8*i +: 8] = 8'sd2;
      end
      if_a.bias = 8'sd3; if_a.relu_en = 1'b0; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      n = 0; busy_bad = 1'b0;
      while (if_a.done !== 1'b1 && n < 100) begin
         if (if_a.busy !== 1'b1) busy_bad = 1'b1;
         @(negedge clk); n++;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", n); end
      checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL basic_busy_high got=%b exp=0 lapses", busy_bad); end
      checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b exp=0", if_a.busy); end
      checks++; if (if_a.result_raw !== 21'sd11) begin errors++; $display("FAIL basic_raw got=%0d exp=11", if_a.result_raw); end
      checks++; if (if_a.result_shifted !== 21'sd0) begin errors++; $display("FAIL basic_shifted got=%0d exp=0", if_a.result_shifted); end
      checks++; if (if_a.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", if_a.ovf); end
      @(negedge clk);
      checks++; if (if_a.done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got=%b exp=0", if_a.done); end
      checks++; if (if_a.result_raw !== 21'sd11) begin errors++; $display("FAIL basic_hold got=%0d exp=11", if_a.result_raw); end
   endtask

   task automatic test_padding();
      int n;
      for (int i = 0; i < 5; i++) begin
         if_b.in_vec[8*i +: 8] = 8'(i + 1);
         if_b.wt_vec[8*i +: 8] = 8'sd1;
      end
      if_b.bias = -8'sd2; if_b.relu_en = 1'b0; if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      n = 0;
      while (if_b.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL pad_latency got=%0d exp=3", n); end
      checks++; if (if_b.result_raw !== 21'sd13) begin errors++; $display("FAIL pad_raw got=%0d exp=13", if_b.result_raw); end
   endtask

   task automatic test_relu();
      int n;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 62; i++) begin
            if_c.in_vec[8*i +: 8] = 8'h80;
            if_c.wt_vec[8*i +: 8] = 8'h7F;
         end
         if_c.bias = 8'sd0; if_c.relu_en = (pass == 1); if_c.start = 1'b1;
         @(negedge clk);
         if_c.start = 1'b0; if_c.relu_en = 1'b0;
         n = 0;
         while (if_c.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         checks++; if (n !== 31) begin errors++; $display("FAIL relu%0d_latency got=%0d exp=31", pass, n); end
         if (pass == 0) begin
            checks++; if (if_c.result_raw !== -21'sd1007872) begin errors++; $display("FAIL neg_raw got=%0d exp=-1007872", if_c.result_raw); end
            checks++; if (if_c.result_shifted !== -21'sd1969) begin errors++; $display("FAIL neg_shifted got=%0d exp=-1969", if_c.result_shifted); end
         end else begin
            checks++; if (if_c.result_raw !== 21'sd0) begin errors++; $display("FAIL relu_raw got=%0d exp=0", if_c.result_raw); end
            checks++; if (if_c.result_shifted !== 21'sd0) begin errors++; $display("FAIL relu_shifted got=%0d exp=0", if_c.result_shifted); end
            checks++; if (if_c.ovf !== 1'b0) begin errors++; $display("FAIL relu_ovf got=%b exp=0", if_c.ovf); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      int n;
      for (int i = 0; i < 64; i++) begin
         if_d.in_vec[8*i +: 8] = 8'h80;
         if_d.wt_vec[8*i +: 8] = 8'h80;
      end
      if_d.bias = 8'sd0; if_d.relu_en = 1'b0; if_d.start = 1'b1;
      @(negedge clk);
      if_d.start = 1'b0;
      n = 0;
      while (if_d.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 16) begin errors++; $display("FAIL sat_latency got=%0d exp=16", n); end
      checks++; if (if_d.result_raw !== 21'sd1048575) begin errors++; $display("FAIL sat_raw got=%0d exp=1048575", if_d.result_raw); end
      checks++; if (if_d.result_shifted !== 21'sd2047) begin errors++; $display("FAIL sat_shifted got=%0d exp=2047", if_d.result_shifted); end
      checks++; if (if_d.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", if_d.ovf); end
   endtask

   task automatic test_start_ignored();
      int n;
      for (int i = 0; i < 62; i++) begin
         if_c.in_vec[8*i +: 8] = 8'sd1;
         if_c.wt_vec[8*i +: 8] = 8'sd1;
      end
      if_c.bias = 8'sd0; if_c.relu_en = 1'b0; if_c.start = 1'b1;
      @(negedge clk);
      if_c.start = 1'b0;
      n = 0;
      while (if_c.done !== 1'b1 && n < 100) begin
         if (n == 5) begin
            for (int i = 0; i < 62; i++) begin
               if_c.in_vec[8*i +: 8] = 8'sd2;
               if_c.wt_vec[8*i +: 8] = 8'sd3;
            end
            if_c.bias = 8'sd5; if_c.start = 1'b1;
         end else begin
            if_c.start = 1'b0;
         end
         @(negedge clk); n++;
      end
      if_c.start = 1'b0;
      checks++; if (n !== 31) begin errors++; $display("FAIL ignore_latency got=%0d exp=31", n); end
      checks++; if (if_c.result_raw !== 21'sd62) begin errors++; $display("FAIL ignore_raw got=%0d exp=62", if_c.result_raw); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int n;
      bit seen;
      for (int i = 0; i < 62; i++) begin
         if_c.in_vec[8*i +: 8] = 8'h80;
         if_c.wt_vec[8*i +: 8] = 8'h7F;
      end
      if_c.bias = 8'sd0; if_c.start = 1'b1;
      @(negedge clk);
      if_c.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (if_c.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", if_c.busy); end
      checks++; if (if_c.result_raw !== 21'sd0) begin errors++; $display("FAIL abort_raw got=%0d exp=0", if_c.result_raw); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (if_c.done !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen); end
      if_c.start = 1'b1;
      @(negedge clk);
      if_c.start = 1'b0;
      n = 0;
      while (if_c.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 31) begin errors++; $display("FAIL fresh_latency got=%0d exp=31", n); end
      checks++; if (if_c.result_raw !== -21'sd1007872) begin errors++; $display("FAIL fresh_raw got=%0d exp=-1007872", if_c.result_raw); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4; i++) begin
         if_a.in_vec[8*i +: 8] = 8'sd1;
         if_a.wt_vec[8*i +: 8] = 8'sd2;
      end
      if_a.bias = 8'sd3; if_a.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) if_a.in_vec[8*i +: 8] = 8'sd2;
      n = 0;
      while (if_a.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=2", n); end
      checks++; if (if_a.result_raw !== 21'sd11) begin errors++; $display("FAIL b2b_first_raw got=%0d exp=11", if_a.result_raw); end
      @(negedge clk);
      if_a.start = 1'b0;
      checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b exp=1", if_a.busy); end
      n = 0;
      while (if_a.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=2", n); end
      checks++; if (if_a.result_raw !== 21'sd19) begin errors++; $display("FAIL b2b_second_raw got=%0d exp=19", if_a.result_raw); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_padding();
      test_relu();
      test_saturation();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
